// File: rtl/vfpu_dc_pkg.sv
// Shared types for the VFPU issue arbiter: single-bit port type, arbiter state and datapath width.
package vfpu_dc_pkg;
    typedef logic BIT;
    typedef enum logic [1:0] {RUN, DRAIN, STOP} arb_st_t;
    localparam int VFPU_W = 32;
endpackage

// File: rtl/vfpu_issue_arb_if.sv
// Requester-lane and VFPU-side signals of the issue arbiter; slave = arbiter, master = lanes/VFPU/bench.
interface vfpu_issue_arb_if #(parameter int NUM_REQ = 4);
    import vfpu_dc_pkg::*;

    BIT [NUM_REQ-1:0]        req_vld;
    BIT [NUM_REQ*VFPU_W-1:0] req_opa;
    BIT [NUM_REQ*VFPU_W-1:0] req_opb;
    BIT [NUM_REQ*VFPU_W-1:0] req_opc;
    BIT [NUM_REQ-1:0]        req_rdy;
    BIT                      op_vld;
    BIT [VFPU_W-1:0]         operand_a;
    BIT [VFPU_W-1:0]         operand_b;
    BIT [VFPU_W-1:0]         operand_c;
    BIT [VFPU_W-1:0]         res;
    BIT                      res_rdy;
    BIT [NUM_REQ-1:0]        rsp_vld;
    BIT [VFPU_W-1:0]         rsp_data;

    modport slave (
        input  req_vld, req_opa, req_opb, req_opc, res, res_rdy,
        output req_rdy, op_vld, operand_a, operand_b, operand_c, rsp_vld, rsp_data
    );

    modport master (
        output req_vld, req_opa, req_opb, req_opc, res, res_rdy,
        input  req_rdy, op_vld, operand_a, operand_b, operand_c, rsp_vld, rsp_data
    );
endinterface

// File: rtl/vfpu_tag_fifo.sv
// Sync FIFO holding the owning lane of each in-flight op; head visible combinationally on dout.
// Push while full is only legal together with a pop in the same cycle.
module vfpu_tag_fifo
    import vfpu_dc_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  BIT             clk,
    input  BIT             rst,
    input  BIT             push,
    input  BIT             pop,
    input  BIT [WIDTH-1:0] din,
    output BIT [WIDTH-1:0] dout,
    output BIT             empty,
    output BIT             full
);
    localparam int AW = $clog2(DEPTH);

    BIT [WIDTH-1:0] mem_q [DEPTH];
    BIT [AW:0]      wr_ptr_q, wr_ptr_d;
    BIT [AW:0]      rd_ptr_q, rd_ptr_d;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/vfpu_issue_arb.sv
// Round-robin arbiter sharing one pipelined VFPU among NUM_REQ lanes; issue 1 cycle after accept, results routed back 1 cycle after res_rdy.
// Grants stop when MAX_OUT ops are in flight (unless one retires) or while draining; VFPU_ARB_PERF_EN adds perf_issue/perf_stall counters.
module vfpu_issue_arb
    import vfpu_dc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 8
) (
    input  BIT                  clk,
    input  BIT                  rst,
    vfpu_issue_arb_if.slave     bus,
    input  BIT                  drain,
    output BIT                  idle,
    output BIT                  err_orphan
`ifdef VFPU_ARB_PERF_EN
    ,
    output BIT [31:0]           perf_issue,
    output BIT [31:0]           perf_stall
`endif
);
    localparam int LW = $clog2(NUM_REQ);

    arb_st_t         st_q, st_d;
    BIT [LW-1:0]     ptr_q, ptr_d;
    BIT [LW-1:0]     gnt_idx, cand;
    BIT              gnt_vld, grant_ok, accept;
    BIT [NUM_REQ-1:0] req_rdy_c;
    BIT              tag_empty, tag_full, tag_pop;
    BIT [LW-1:0]     tag_head;
    BIT              op_vld_q;
    BIT [VFPU_W-1:0] opa_q, opb_q, opc_q;
    BIT [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
    BIT [VFPU_W-1:0] rsp_data_q;
    BIT              err_q;

    // First requesting lane after the last granted one.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = LW'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_vld && bus.req_vld[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign tag_pop  = bus.res_rdy && !tag_empty;
    // A retire in this cycle frees the slot the new op will take.
    assign grant_ok = (st_q == RUN) && !drain && (!tag_full || tag_pop);
    assign accept   = gnt_vld && grant_ok;
    assign ptr_d    = accept ? gnt_idx : ptr_q;

    always_comb begin
        req_rdy_c = '0;
        if (accept) req_rdy_c[gnt_idx] = 1'b1;
    end

    always_comb begin
        rsp_vld_d = '0;
        if (tag_pop) rsp_vld_d[tag_head] = 1'b1;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            RUN:     if (drain) st_d = DRAIN;
            DRAIN:   if (!drain) st_d = RUN;
                     else if (tag_empty) st_d = STOP;
            STOP:    if (!drain) st_d = RUN;
            default: st_d = RUN;
        endcase
    end

    vfpu_tag_fifo #(.WIDTH(LW), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (tag_pop),
        .din   (gnt_idx),
        .dout  (tag_head),
        .empty (tag_empty),
        .full  (tag_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= RUN;
            ptr_q      <= LW'(NUM_REQ - 1);
            op_vld_q   <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            opc_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            st_q      <= st_d;
            ptr_q     <= ptr_d;
            op_vld_q  <= accept;
            rsp_vld_q <= rsp_vld_d;
            if (accept) begin
                opa_q <= bus.req_opa[gnt_idx*VFPU_W +: VFPU_W];
                opb_q <= bus.req_opb[gnt_idx*VFPU_W +: VFPU_W];
                opc_q <= bus.req_opc[gnt_idx*VFPU_W +: VFPU_W];
            end
            if (tag_pop) rsp_data_q <= bus.res;
            if (bus.res_rdy && tag_empty) err_q <= 1'b1;
        end
    end

    assign bus.req_rdy   = req_rdy_c;
    assign bus.op_vld    = op_vld_q;
    assign bus.operand_a = opa_q;
    assign bus.operand_b = opb_q;
    assign bus.operand_c = opc_q;
    assign bus.rsp_vld   = rsp_vld_q;
    assign bus.rsp_data  = rsp_data_q;
    assign idle          = tag_empty && !accept;
    assign err_orphan    = err_q;

`ifdef VFPU_ARB_PERF_EN
    BIT [31:0] perf_issue_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (accept && perf_issue_q != 32'hFFFF_FFFF) perf_issue_q <= perf_issue_q + 32'd1;
            if ((|bus.req_vld) && !accept && perf_stall_q != 32'hFFFF_FFFF)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issue = perf_issue_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_vfpu_issue_arb.sv
// Bench for vfpu_issue_arb: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_vfpu_issue_arb;
    import vfpu_dc_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int MAX_OUT = 8;

    logic clk = 1'b0;
    logic rst;
    logic drain;
    logic idle;
    logic err_orphan;
`ifdef VFPU_ARB_PERF_EN
    logic [31:0] perf_issue, perf_stall;
`endif

    vfpu_issue_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    vfpu_issue_arb #(.NUM_REQ(NUM_REQ), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .drain      (drain),
        .idle       (idle),
        .err_orphan (err_orphan)
`ifdef VFPU_ARB_PERF_EN
        ,
        .perf_issue (perf_issue),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of owning lanes, last-granted lane, drain mode.
    int          m_ptr;
    int          m_tags[$];
    int          m_mode;   // 0 running, 1 draining, 2 stopped
    logic        e_op_vld;
    logic [31:0] e_opa, e_opb, e_opc;
    logic [3:0]  e_rsp_vld;
    logic [31:0] e_rsp_data;
    logic        e_err;

    function automatic int model_grant();
        if (m_mode != 0 || drain) return -1;
        if (m_tags.size() >= MAX_OUT && !bus.res_rdy) return -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_ptr + k) % NUM_REQ;
            if (bus.req_vld[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy();
        int g;
        g = model_grant();
        return (g < 0) ? 4'b0000 : 4'(1 << g);
    endfunction

    function automatic logic exp_idle();
        return (m_tags.size() == 0) && (model_grant() < 0);
    endfunction

    task automatic model_reset();
        m_ptr = NUM_REQ - 1;
        m_tags.delete();
        m_mode = 0;
        e_op_vld = 1'b0;
        e_opa = '0; e_opb = '0; e_opc = '0;
        e_rsp_vld = '0;
        e_rsp_data = '0;
        e_err = 1'b0;
    endtask

    task automatic model_commit(input int g);
        int was;
        was = m_tags.size();
        e_rsp_vld = '0;
        if (bus.res_rdy) begin
            if (was > 0) begin
                int h;
                h = m_tags.pop_front();
                e_rsp_vld = 4'(1 << h);
                e_rsp_data = bus.res;
            end else begin
                e_err = 1'b1;
            end
        end
        e_op_vld = (g >= 0);
        if (g >= 0) begin
            m_tags.push_back(g);
            m_ptr = g;
            e_opa = bus.req_opa[32*g +: 32];
            e_opb = bus.req_opb[32*g +: 32];
            e_opc = bus.req_opc[32*g +: 32];
        end
        case (m_mode)
            0: if (drain) m_mode = 1;
            1: if (!drain) m_mode = 0; else if (was == 0) m_mode = 2;
            default: if (!drain) m_mode = 0;
        endcase
    endtask

    // Advance one clock; inputs must be stable from the preceding negedge.
    task automatic step();
        int g;
        g = model_grant();
        @(posedge clk);
        model_commit(g);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drain = 1'b0;
        bus.req_vld = '0;
        bus.res_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.req_opa = '0; bus.req_opb = '0; bus.req_opc = '0; bus.res = '0;
        do_reset();
        #1;
        checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy got=%b exp=0000", bus.req_rdy); end
        checks++; if (bus.op_vld !== 1'b0) begin errors++; $display("FAIL reset_op_vld got=%b exp=0", bus.op_vld); end
        checks++; if (bus.operand_a !== 32'h0) begin errors++; $display("FAIL reset_operand_a got=%h exp=0", bus.operand_a); end
        checks++; if (bus.rsp_vld !== 4'b0000) begin errors++; $display("FAIL reset_rsp_vld got=%b exp=0000", bus.rsp_vld); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_orphan); end
    endtask

    task automatic test_single();
        bus.req_vld = 4'b0001;
        bus.req_opa[31:0] = 32'h3F80_0000;
        #1;
        checks++; if (bus.req_rdy !== 4'b0001) begin errors++; $display("FAIL single_req_rdy got=%b exp=0001", bus.req_rdy); end
        step();
        bus.req_vld = '0;
        #1;
        checks++; if (bus.op_vld !== 1'b1) begin errors++; $display("FAIL single_op_vld got=%b exp=1", bus.op_vld); end
        checks++; if (bus.operand_a !== 32'h3F80_0000) begin errors++; $display("FAIL single_operand_a got=%h exp=3f800000", bus.operand_a); end
        bus.res = 32'h4000_0000;
        bus.res_rdy = 1'b1;
        step();
        bus.res_rdy = 1'b0;
        checks++; if (bus.op_vld !== 1'b0) begin errors++; $display("FAIL single_op_vld_low got=%b exp=0", bus.op_vld); end
        checks++; if (bus.rsp_vld !== 4'b0001) begin errors++; $display("FAIL single_rsp_vld got=%b exp=0001", bus.rsp_vld); end
        checks++; if (bus.rsp_data !== 32'h4000_0000) begin errors++; $display("FAIL single_rsp_data got=%h exp=40000000", bus.rsp_data); end
        step();
        checks++; if (bus.rsp_vld !== 4'b0000) begin errors++; $display("FAIL single_rsp_pulse got=%b exp=0000", bus.rsp_vld); end
    endtask

    // Round-robin fairness, then the full-window boundary and draining the window.
    task automatic test_rr_and_full();
        int cnt[NUM_REQ];
        do_reset();
        foreach (cnt[i]) cnt[i] = 0;
        bus.req_vld = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            bus.req_opa = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++; if (bus.req_rdy !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, bus.req_rdy, 4'(1 << (i % 4))); end
            for (int l = 0; l < NUM_REQ; l++) if (bus.req_rdy[l]) cnt[l]++;
            step();
            checks++; if (bus.operand_a !== e_opa) begin errors++; $display("FAIL rr_operand_a[%0d] got=%h exp=%h", i, bus.operand_a, e_opa); end
        end
        for (int l = 0; l < NUM_REQ; l++) begin
            checks++; if (cnt[l] != 2) begin errors++; $display("FAIL rr_count[%0d] got=%0d exp=2", l, cnt[l]); end
        end
        #1;
        checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL full_no_grant got=%b exp=0000", bus.req_rdy); end
        step();
        bus.res = $urandom;
        bus.res_rdy = 1'b1;
        #1;
        checks++; if (bus.req_rdy !== 4'b0001) begin errors++; $display("FAIL full_retire_grant got=%b exp=0001", bus.req_rdy); end
        step();
        bus.res_rdy = 1'b0;
        #1;
        checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL full_still_full got=%b exp=0000", bus.req_rdy); end
        checks++; if (bus.rsp_vld !== 4'b0001) begin errors++; $display("FAIL full_first_rsp got=%b exp=0001", bus.rsp_vld); end
        bus.req_vld = '0;
        for (int i = 0; i < 8; i++) begin
            bus.res = $urandom;
            bus.res_rdy = 1'b1;
            step();
            checks++; if (bus.rsp_vld !== e_rsp_vld || bus.rsp_data !== e_rsp_data) begin errors++; $display("FAIL full_drain_rsp[%0d] got=%b/%h exp=%b/%h", i, bus.rsp_vld, bus.rsp_data, e_rsp_vld, e_rsp_data); end
        end
        bus.res_rdy = 1'b0;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full_idle_after got=%b exp=1", idle); end
    endtask

    task automatic test_order();
        logic [3:0]  lanes[3];
        logic [31:0] vals[3];
        lanes = '{4'b0100, 4'b0001, 4'b1000};
        vals  = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.req_vld = lanes[i];
            #1;
            checks++; if (bus.req_rdy !== lanes[i]) begin errors++; $display("FAIL order_grant[%0d] got=%b exp=%b", i, bus.req_rdy, lanes[i]); end
            step();
        end
        bus.req_vld = '0;
        for (int i = 0; i < 3; i++) begin
            bus.res = vals[i];
            bus.res_rdy = 1'b1;
            step();
            checks++; if (bus.rsp_vld !== lanes[i] || bus.rsp_data !== vals[i]) begin errors++; $display("FAIL order_rsp[%0d] got=%b/%h exp=%b/%h", i, bus.rsp_vld, bus.rsp_data, lanes[i], vals[i]); end
        end
        bus.res_rdy = 1'b0;
    endtask

    task automatic test_drain();
        bit resumed;
        do_reset();
        bus.req_vld = 4'b0111;
        for (int i = 0; i < 3; i++) step();
        drain = 1'b1;
        bus.req_vld = 4'b1111;
        #1;
        checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL drain_same_cycle got=%b exp=0000", bus.req_rdy); end
        for (int i = 0; i < 3; i++) begin
            bus.res = $urandom;
            bus.res_rdy = 1'b1;
            #1;
            checks++; if (idle !== 1'b0 || bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL drain_busy[%0d] got=idle %b rdy %b exp=idle 0 rdy 0000", i, idle, bus.req_rdy); end
            step();
        end
        bus.res_rdy = 1'b0;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL drain_idle got=%b exp=1", idle); end
        step();
        step();
        #1;
        checks++; if (idle !== 1'b1 || bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL drain_stopped got=idle %b rdy %b exp=idle 1 rdy 0000", idle, bus.req_rdy); end
        drain = 1'b0;
        resumed = 1'b0;
        for (int i = 0; i < 4 && !resumed; i++) begin
            #1;
            checks++; if (bus.req_rdy !== exp_rdy()) begin errors++; $display("FAIL drain_resume_model[%0d] got=%b exp=%b", i, bus.req_rdy, exp_rdy()); end
            if (bus.req_rdy != 4'b0000) resumed = 1'b1;
            step();
        end
        checks++; if (!resumed) begin errors++; $display("FAIL drain_resume got=no grant in 4 cycles exp=grant"); end
        bus.req_vld = '0;
    endtask

    task automatic test_orphan();
        do_reset();
        bus.res = 32'h1234_5678;
        bus.res_rdy = 1'b1;
        step();
        bus.res_rdy = 1'b0;
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
        checks++; if (bus.rsp_vld !== 4'b0000) begin errors++; $display("FAIL orphan_no_rsp got=%b exp=0000", bus.rsp_vld); end
        step();
        checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
        do_reset();
        checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_clear got=%b exp=0", err_orphan); end
        bus.req_vld = 4'b0011;
        step();
        step();
        do_reset();
        bus.res_rdy = 1'b1;
        step();
        bus.res_rdy = 1'b0;
        checks++; if (err_orphan !== 1'b1 || bus.rsp_vld !== 4'b0000) begin errors++; $display("FAIL orphan_after_rst got=err %b rsp %b exp=err 1 rsp 0000", err_orphan, bus.rsp_vld); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) drain = ~drain;
            bus.req_vld = 4'($urandom);
            bus.req_opa = {$urandom, $urandom, $urandom, $urandom};
            bus.req_opb = {$urandom, $urandom, $urandom, $urandom};
            bus.req_opc = {$urandom, $urandom, $urandom, $urandom};
            bus.res     = $urandom;
            bus.res_rdy = (m_tags.size() > 0) && ($urandom_range(0, 99) < 45);
            #1;
            checks++; if (bus.req_rdy !== exp_rdy() || idle !== exp_idle()) begin errors++; $display("FAIL rand_comb[%0d] got=rdy %b idle %b exp=rdy %b idle %b", i, bus.req_rdy, idle, exp_rdy(), exp_idle()); end
            step();
            checks++;
            if (bus.op_vld !== e_op_vld || bus.operand_a !== e_opa || bus.operand_b !== e_opb || bus.operand_c !== e_opc) begin
                errors++;
                $display("FAIL rand_issue[%0d] got=%b %h %h %h exp=%b %h %h %h", i, bus.op_vld, bus.operand_a, bus.operand_b, bus.operand_c, e_op_vld, e_opa, e_opb, e_opc);
            end
            checks++;
            if (bus.rsp_vld !== e_rsp_vld || (e_rsp_vld != 0 && bus.rsp_data !== e_rsp_data) || err_orphan !== e_err) begin
                errors++;
                $display("FAIL rand_rsp[%0d] got=%b %h err %b exp=%b %h err %b", i, bus.rsp_vld, bus.rsp_data, err_orphan, e_rsp_vld, e_rsp_data, e_err);
            end
        end
        drain = 1'b0;
        bus.req_vld = '0;
        bus.res_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drain = 1'b0;
        bus.req_vld = '0;
        bus.req_opa = '0;
        bus.req_opb = '0;
        bus.req_opc = '0;
        bus.res = '0;
        bus.res_rdy = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_rr_and_full();
        test_order();
        test_drain();
        test_orphan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
